proximity_alarm_ctrl: RTL and testbench
=======================================

// Module: proximity_alarm_ctrl
// PURPOSE
//   Multi-channel successor to the single-sensor SAFE/WARNING/DANGER logic. Classifies N_CH raw
//   ultrasonic distance streams into zones with hysteresis and selects the nearest channel.
//   Drives a zone-dependent buzzer pattern and a req/done handshake toward the LCD row writer.
//   Sits between the hc_sr04 instances and lcd_display, in the clk_1MHz domain.
// PARAMETERS
//   N_CH        2        number of sensor channels (1..8)
//   DW          16       distance sample width, raw sensor units
//   WARN_TH     1000     d < WARN_TH enters WARNING
//   DANGER_TH   500      d < DANGER_TH enters DANGER; must be < WARN_TH
//   HYST        50       exit margin: leave a zone only when d >= threshold + HYST
//   BEEP_HALF   62500    WARNING buzzer on/off half-period, cycles
//   REFRESH_CYC 1000000  forced LCD refresh interval, cycles
//   MIN_GAP     2000     idle cycles enforced after each lcd_done
// PORTS
//   clk_1MHz     in   1          system clock
//   rst          in   1          asynchronous reset, active high
//   sample_valid in   N_CH       1-cycle pulse per channel, new sample present
//   sample_data  in   N_CH*DW    channel k at [k*DW +: DW]
//   zone         out  2          zone of nearest channel: 0 SAFE, 1 WARNING, 2 DANGER
//   nearest_ch   out  clog2(N_CH) (min 1)  index of nearest channel
//   nearest_dist out  DW         filtered distance of nearest channel
//   buzzer       out  1          alarm output
//   lcd_req      out  1          held high until lcd_done
//   lcd_done     in   1          1-cycle pulse, LCD write complete
//   disp_zone    out  2          snapshot of zone, stable while lcd_req high
//   disp_dist    out  DW         snapshot of nearest_dist, stable while lcd_req high
// BEHAVIOUR
//   Reset: zone=0, nearest_ch=0, nearest_dist=all-ones, buzzer=0, lcd_req=0, disp_*=0,
//     per-channel dist=all-ones, per-channel zone=SAFE, timers cleared, pending=0.
//   Reset asserted mid-handshake drops lcd_req immediately; any pending update is discarded.
//   Stage 1 (cycle after sample_valid[k]): register sample into dist[k].
//     sample==0 means no echo: ignore it; dist[k] and zone[k] hold.
//   Stage 1 zone[k] update, using the new sample d:
//     SAFE->DANGER if d<DANGER_TH, else SAFE->WARN if d<WARN_TH.
//     WARN->DANGER if d<DANGER_TH; WARN->SAFE if d>=WARN_TH+HYST.
//     DANGER->SAFE if d>=WARN_TH+HYST, else DANGER->WARN if d>=DANGER_TH+HYST.
//     Threshold sums are computed DW+1 bits wide, with no wrap.
//   Stage 2: nearest = min dist[k]; a tie goes to the lowest index. zone/nearest_* are registered.
//     Latency from sample_valid to outputs: 2 cycles. Simultaneous valids on all channels are legal.
//   Buzzer: DANGER gives a constant 1; SAFE gives 0.
//     WARNING gives a square wave: 1 for BEEP_HALF cycles, then 0 for BEEP_HALF cycles.
//     The pattern restarts with buzzer=1 on the first cycle zone==WARNING after any other zone.
//   LCD FSM states: IDLE, REQ, GAP.
//     Trigger = change of zone or nearest_dist, or the refresh counter reaching REFRESH_CYC-1.
//     IDLE with trigger or pending -> REQ; same edge latches disp_* and sets lcd_req=1, pending=0.
//     REQ: on lcd_done -> GAP with lcd_req=0. lcd_done outside REQ is ignored.
//     GAP: count MIN_GAP cycles, then -> IDLE.
//     A trigger in REQ or GAP sets pending; a trigger coinciding with lcd_done also sets pending.
//     Refresh counter restarts at every REQ entry.
// CONFIGURATION
//   MEDIAN3_EN defined: per-channel median of the last 3 non-zero samples feeds stage 1.
//     This adds 1 cycle (latency 3). Until 3 samples are collected, the raw sample is used.
//   MEDIAN3_EN undefined: raw samples are used and latency is 2. No median registers exist.
// TESTING
//   (bench: N_CH=2, BEEP_HALF=4, REFRESH_CYC=200, MIN_GAP=8)
//   1. Reset, no samples -> zone=0, buzzer=0, nearest_dist=16'hFFFF, lcd_req=0 until refresh at cycle 200.
//   2. ch0 samples 1200, 990, 1020, 1060 -> WARN after 990; stays WARN at 1020; SAFE at 1060.
//      Buzzer toggles every 4 cycles while in WARN.
//   3. ch0=800 and ch1=300 in the same cycle -> 2 cycles later nearest_ch=1, zone=2, buzzer=1.
//      Tie ch0=ch1=300 gives nearest_ch=0.
//   4. Zone change while lcd_req high -> disp_* unchanged until lcd_done.
//      Then 8 idle cycles, then a second lcd_req carrying the new values.
//   5. sample 0 on ch1 -> no change.
//      Reset during REQ -> lcd_req=0 asynchronously; no request after release until a trigger.
//   6. MEDIAN3_EN: ch0 samples 900, 100, 950 -> third output uses median 900 (WARN, not DANGER),
//      at latency 3.

Source files
------------

// File: rtl/proximity_alarm_ctrl.sv
// Multi-channel proximity zoning with hysteresis, nearest-channel select, buzzer pattern and
// LCD req/done handshake. Define MEDIAN3_EN to add a 3-sample median pre-filter (latency 3).
module proximity_alarm_ctrl #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned DW          = 16,
  parameter int unsigned WARN_TH     = 1000,
  parameter int unsigned DANGER_TH   = 500,
  parameter int unsigned HYST        = 50,
  parameter int unsigned BEEP_HALF   = 62500,
  parameter int unsigned REFRESH_CYC = 1000000,
  parameter int unsigned MIN_GAP     = 2000
) (
  input  logic                                      clk_1MHz,
  input  logic                                      rst,
  input  logic [N_CH-1:0]                           sample_valid,
  input  logic [N_CH*DW-1:0]                        sample_data,
  output logic [1:0]                                zone,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] nearest_ch,
  output logic [DW-1:0]                             nearest_dist,
  output logic                                      buzzer,
  output logic                                      lcd_req,
  input  logic                                      lcd_done,
  output logic [1:0]                                disp_zone,
  output logic [DW-1:0]                             disp_dist
);

  localparam int unsigned CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned DW1 = DW + 1;
  localparam int unsigned BW  = $clog2(BEEP_HALF + 1);
  localparam int unsigned RW  = $clog2(REFRESH_CYC + 1);
  localparam int unsigned GW  = $clog2(MIN_GAP + 1);

  localparam logic [DW:0] WARN_LIM    = DW1'(WARN_TH);
  localparam logic [DW:0] DANGER_LIM  = DW1'(DANGER_TH);
  localparam logic [DW:0] WARN_EXIT   = DW1'(WARN_TH + HYST);
  localparam logic [DW:0] DANGER_EXIT = DW1'(DANGER_TH + HYST);

  localparam logic [1:0] Z_SAFE   = 2'd0;
  localparam logic [1:0] Z_WARN   = 2'd1;
  localparam logic [1:0] Z_DANGER = 2'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [N_CH-1:0] s1_valid;
  logic [DW-1:0]   s1_data [N_CH];

`ifdef MEDIAN3_EN
  logic [DW-1:0]   h0_q [N_CH];
  logic [DW-1:0]   h1_q [N_CH];
  logic [1:0]      hcnt_q [N_CH];
  logic [N_CH-1:0] mv_q;
  logic [DW-1:0]   md_q [N_CH];

  function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    if (a >= b) begin
      if (b >= c)      return b;
      else if (a >= c) return c;
      else             return a;
    end else begin
      if (a >= c)      return a;
      else if (b >= c) return c;
      else             return b;
    end
  endfunction

  // Median pre-filter: zero samples never enter the history; raw value until 2 are stored.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      mv_q <= '0;
      for (int k = 0; k < N_CH; k++) begin
        h0_q[k]   <= '0;
        h1_q[k]   <= '0;
        hcnt_q[k] <= '0;
        md_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        mv_q[k] <= 1'b0;
        if (sample_valid[k] && (sample_data[k*DW +: DW] != '0)) begin
          mv_q[k] <= 1'b1;
          md_q[k] <= (hcnt_q[k] == 2'd2) ? med3(sample_data[k*DW +: DW], h0_q[k], h1_q[k])
                                         : sample_data[k*DW +: DW];
          h0_q[k] <= sample_data[k*DW +: DW];
          h1_q[k] <= h0_q[k];
          if (hcnt_q[k] != 2'd2) hcnt_q[k] <= hcnt_q[k] + 2'd1;
        end
      end
    end
  end

  always_comb begin
    s1_valid = mv_q;
    for (int k = 0; k < N_CH; k++) s1_data[k] = md_q[k];
  end
`else
  always_comb begin
    s1_valid = sample_valid;
    for (int k = 0; k < N_CH; k++) s1_data[k] = sample_data[k*DW +: DW];
  end
`endif

  function automatic logic [1:0] next_zone(input logic [1:0] z, input logic [DW-1:0] d);
    logic [DW:0] dx;
    dx = {1'b0, d};
    case (z)
      Z_SAFE:   return (dx < DANGER_LIM) ? Z_DANGER : ((dx < WARN_LIM) ? Z_WARN : Z_SAFE);
      Z_WARN:   return (dx < DANGER_LIM) ? Z_DANGER : ((dx >= WARN_EXIT) ? Z_SAFE : Z_WARN);
      Z_DANGER: return (dx >= WARN_EXIT) ? Z_SAFE : ((dx >= DANGER_EXIT) ? Z_WARN : Z_DANGER);
      default:  return Z_SAFE;
    endcase
  endfunction

  logic [DW-1:0]  dist_q [N_CH];
  logic [DW-1:0]  dist_d [N_CH];
  logic [1:0]     czone_q [N_CH];
  logic [1:0]     czone_d [N_CH];
  logic [1:0]     zone_q, zone_d;
  logic [CHW-1:0] nch_q, nch_d;
  logic [DW-1:0]  ndist_q, ndist_d;
  logic           buzzer_q, buzzer_d;
  logic [BW-1:0]  beep_q, beep_d;
  logic [1:0]     state_q, state_d;
  logic           lcd_req_q, lcd_req_d;
  logic [1:0]     disp_zone_q, disp_zone_d;
  logic [DW-1:0]  disp_dist_q, disp_dist_d;
  logic           pending_q, pending_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [RW-1:0]  refresh_q, refresh_d;
  logic           trigger;

  // Stage 1: per-channel distance and hysteretic zone; zero means no echo.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      dist_d[k]  = dist_q[k];
      czone_d[k] = czone_q[k];
      if (s1_valid[k] && (s1_data[k] != '0)) begin
        dist_d[k]  = s1_data[k];
        czone_d[k] = next_zone(czone_q[k], s1_data[k]);
      end
    end
  end

  // Stage 2: nearest channel, strict compare keeps the lowest index on ties.
  always_comb begin
    ndist_d = dist_q[0];
    nch_d   = '0;
    zone_d  = czone_q[0];
    for (int unsigned k = 1; k < N_CH; k++) begin
      if (dist_q[k] < ndist_d) begin
        ndist_d = dist_q[k];
        nch_d   = CHW'(k);
        zone_d  = czone_q[k];
      end
    end
  end

  // Buzzer follows the next zone so it changes on the same edge as zone.
  always_comb begin
    buzzer_d = 1'b0;
    beep_d   = '0;
    case (zone_d)
      Z_DANGER: buzzer_d = 1'b1;
      Z_WARN: begin
        if (zone_q != Z_WARN) begin
          buzzer_d = 1'b1;
        end else if (beep_q == BW'(BEEP_HALF - 1)) begin
          buzzer_d = ~buzzer_q;
        end else begin
          buzzer_d = buzzer_q;
          beep_d   = beep_q + BW'(1);
        end
      end
      default: buzzer_d = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    lcd_req_d   = lcd_req_q;
    disp_zone_d = disp_zone_q;
    disp_dist_d = disp_dist_q;
    pending_d   = pending_q;
    gap_d       = gap_q;
    refresh_d   = (refresh_q == RW'(REFRESH_CYC - 1)) ? '0 : refresh_q + RW'(1);
    trigger     = (zone_d != zone_q) || (ndist_d != ndist_q) ||
                  (refresh_q == RW'(REFRESH_CYC - 1));
    case (state_q)
      S_IDLE: begin
        if (trigger || pending_q) begin
          state_d     = S_REQ;
          lcd_req_d   = 1'b1;
          disp_zone_d = zone_d;
          disp_dist_d = ndist_d;
          pending_d   = 1'b0;
          refresh_d   = '0;
        end
      end
      S_REQ: begin
        if (trigger) pending_d = 1'b1;
        if (lcd_done) begin
          state_d   = S_GAP;
          lcd_req_d = 1'b0;
          gap_d     = '0;
        end
      end
      S_GAP: begin
        if (trigger) pending_d = 1'b1;
        if (gap_q == GW'(MIN_GAP - 1)) state_d = S_IDLE;
        else                           gap_d   = gap_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        dist_q[k]  <= '1;
        czone_q[k] <= Z_SAFE;
      end
      zone_q      <= Z_SAFE;
      nch_q       <= '0;
      ndist_q     <= '1;
      buzzer_q    <= 1'b0;
      beep_q      <= '0;
      state_q     <= S_IDLE;
      lcd_req_q   <= 1'b0;
      disp_zone_q <= '0;
      disp_dist_q <= '0;
      pending_q   <= 1'b0;
      gap_q       <= '0;
      refresh_q   <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        dist_q[k]  <= dist_d[k];
        czone_q[k] <= czone_d[k];
      end
      zone_q      <= zone_d;
      nch_q       <= nch_d;
      ndist_q     <= ndist_d;
      buzzer_q    <= buzzer_d;
      beep_q      <= beep_d;
      state_q     <= state_d;
      lcd_req_q   <= lcd_req_d;
      disp_zone_q <= disp_zone_d;
      disp_dist_q <= disp_dist_d;
      pending_q   <= pending_d;
      gap_q       <= gap_d;
      refresh_q   <= refresh_d;
    end
  end

  assign zone         = zone_q;
  assign nearest_ch   = nch_q;
  assign nearest_dist = ndist_q;
  assign buzzer       = buzzer_q;
  assign lcd_req      = lcd_req_q;
  assign disp_zone    = disp_zone_q;
  assign disp_dist    = disp_dist_q;

endmodule

// File: tb/tb_proximity_alarm_ctrl.sv
// Directed bench for proximity_alarm_ctrl (N_CH=2, BEEP_HALF=4, REFRESH_CYC=200, MIN_GAP=8).
// Honours MEDIAN3_EN for latency and median-dependent expectations.
module tb_proximity_alarm_ctrl;

`ifdef MEDIAN3_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 2;
`endif

  logic        clk_1MHz = 1'b0;
  logic        rst;
  logic [1:0]  sample_valid;
  logic [31:0] sample_data;
  logic [1:0]  zone;
  logic [0:0]  nearest_ch;
  logic [15:0] nearest_dist;
  logic        buzzer;
  logic        lcd_req;
  logic        lcd_done;
  logic [1:0]  disp_zone;
  logic [15:0] disp_dist;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_1MHz = ~clk_1MHz;

  proximity_alarm_ctrl #(
    .N_CH(2), .DW(16), .WARN_TH(1000), .DANGER_TH(500), .HYST(50),
    .BEEP_HALF(4), .REFRESH_CYC(200), .MIN_GAP(8)
  ) dut (
    .clk_1MHz    (clk_1MHz),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .zone        (zone),
    .nearest_ch  (nearest_ch),
    .nearest_dist(nearest_dist),
    .buzzer      (buzzer),
    .lcd_req     (lcd_req),
    .lcd_done    (lcd_done),
    .disp_zone   (disp_zone),
    .disp_dist   (disp_dist)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    sample_valid = '0;
    sample_data  = '0;
    lcd_done     = 1'b0;
    repeat (2) @(negedge clk_1MHz);
    rst = 1'b0;
  endtask

  // Drive one sample cycle, then wait until the result reaches the outputs.
  task automatic send(input logic [1:0] vmask, input logic [15:0] d0, input logic [15:0] d1);
    sample_valid = vmask;
    sample_data  = {d1, d0};
    @(negedge clk_1MHz);
    sample_valid = '0;
    sample_data  = '0;
    repeat (LAT - 1) @(negedge clk_1MHz);
  endtask

  task automatic lcd_ack();
    lcd_done = 1'b1;
    @(negedge clk_1MHz);
    lcd_done = 1'b0;
  endtask

  initial begin
    int          n;
    logic        seen;
    logic [8:0]  bz;

    // Reset state and refresh-driven request
    do_reset();
    check_eq("rst_zone", 32'(zone), 32'd0);
    check_eq("rst_buzzer", 32'(buzzer), 32'd0);
    check_eq("rst_dist", 32'(nearest_dist), 32'hFFFF);
    check_eq("rst_ch", 32'(nearest_ch), 32'd0);
    check_eq("rst_req", 32'(lcd_req), 32'd0);
    check_eq("rst_disp_dist", 32'(disp_dist), 32'd0);
    n = 0;
    while (!lcd_req && n < 300) begin
      @(negedge clk_1MHz);
      n++;
    end
    check_eq("refresh_cycle", 32'(n), 32'd200);
    check_eq("refresh_disp_dist", 32'(disp_dist), 32'hFFFF);
    lcd_ack();
    check_eq("ack_drop", 32'(lcd_req), 32'd0);

    // WARN hysteresis and buzzer square wave
    do_reset();
    send(2'b01, 16'd1200, 16'd0);
    check_eq("s1200_zone", 32'(zone), 32'd0);
    check_eq("s1200_dist", 32'(nearest_dist), 32'd1200);
    send(2'b01, 16'd990, 16'd0);
    check_eq("s990_zone", 32'(zone), 32'd1);
    bz[0] = buzzer;
    for (int i = 1; i < 9; i++) begin
      @(negedge clk_1MHz);
      bz[i] = buzzer;
    end
    check_eq("warn_beep", 32'(bz), 32'h10F);
    send(2'b01, 16'd1020, 16'd0);
    check_eq("s1020_zone", 32'(zone), 32'd1);
    check_eq("s1020_dist", 32'(nearest_dist), 32'd1020);
    send(2'b01, 16'd1060, 16'd0);
`ifdef MEDIAN3_EN
    check_eq("s1060_zone", 32'(zone), 32'd1);
    check_eq("s1060_dist", 32'(nearest_dist), 32'd1020);
`else
    check_eq("s1060_zone", 32'(zone), 32'd0);
    check_eq("s1060_dist", 32'(nearest_dist), 32'd1060);
    check_eq("s1060_buzzer", 32'(buzzer), 32'd0);
`endif
    do_reset();
    send(2'b01, 16'd999, 16'd0);
    check_eq("s999_zone", 32'(zone), 32'd1);
    send(2'b01, 16'd1050, 16'd0);
    check_eq("s1050_zone", 32'(zone), 32'd0);

    // Nearest select, DANGER, tie and DANGER exit boundary
    do_reset();
    send(2'b11, 16'd800, 16'd300);
    check_eq("sim_ch", 32'(nearest_ch), 32'd1);
    check_eq("sim_zone", 32'(zone), 32'd2);
    check_eq("sim_buzzer", 32'(buzzer), 32'd1);
    check_eq("sim_dist", 32'(nearest_dist), 32'd300);
    repeat (5) @(negedge clk_1MHz);
    check_eq("danger_steady_buzzer", 32'(buzzer), 32'd1);
    send(2'b01, 16'd300, 16'd0);
    check_eq("tie_ch", 32'(nearest_ch), 32'd0);
    check_eq("tie_zone", 32'(zone), 32'd2);
    do_reset();
    send(2'b11, 16'd300, 16'd300);
    send(2'b11, 16'd549, 16'd549);
    check_eq("s549_zone", 32'(zone), 32'd2);
    do_reset();
    send(2'b11, 16'd300, 16'd300);
    send(2'b11, 16'd550, 16'd550);
    check_eq("s550_zone", 32'(zone), 32'd1);
    check_eq("s550_ch", 32'(nearest_ch), 32'd0);

    // Snapshot held during REQ, gap, then second request with new values
    do_reset();
    send(2'b01, 16'd1200, 16'd0);
    check_eq("req1_req", 32'(lcd_req), 32'd1);
    check_eq("req1_disp_dist", 32'(disp_dist), 32'd1200);
    check_eq("req1_disp_zone", 32'(disp_zone), 32'd0);
    send(2'b01, 16'd700, 16'd0);
    check_eq("s700_zone", 32'(zone), 32'd1);
    check_eq("hold_disp_dist", 32'(disp_dist), 32'd1200);
    check_eq("hold_disp_zone", 32'(disp_zone), 32'd0);
    check_eq("hold_req", 32'(lcd_req), 32'd1);
    lcd_ack();
    seen = lcd_req;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk_1MHz);
      seen = seen | lcd_req;
    end
    check_eq("gap_low", 32'(seen), 32'd0);
    n = 0;
    while (!lcd_req && n < 6) begin
      @(negedge clk_1MHz);
      n++;
    end
    check_eq("req2_rise", 32'(lcd_req), 32'd1);
    check_eq("req2_disp_zone", 32'(disp_zone), 32'd1);
    check_eq("req2_disp_dist", 32'(disp_dist), 32'd700);

    // Zero sample ignored; async reset mid-request
    do_reset();
    send(2'b10, 16'd0, 16'd600);
    check_eq("s600_ch", 32'(nearest_ch), 32'd1);
    check_eq("s600_zone", 32'(zone), 32'd1);
    send(2'b10, 16'd0, 16'd0);
    check_eq("zero_dist", 32'(nearest_dist), 32'd600);
    check_eq("zero_zone", 32'(zone), 32'd1);
    check_eq("zero_ch", 32'(nearest_ch), 32'd1);
    check_eq("pre_rst_req", 32'(lcd_req), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_req", 32'(lcd_req), 32'd0);
    repeat (2) @(negedge clk_1MHz);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk_1MHz);
      seen = seen | lcd_req;
    end
    check_eq("post_rst_quiet", 32'(seen), 32'd0);
    send(2'b01, 16'd1200, 16'd0);
    check_eq("post_rst_trigger", 32'(lcd_req), 32'd1);

`ifdef MEDIAN3_EN
    // Median of last three non-zero samples, latency 3
    do_reset();
    send(2'b01, 16'd900, 16'd0);
    check_eq("m900_zone", 32'(zone), 32'd1);
    send(2'b01, 16'd100, 16'd0);
    check_eq("m100_zone", 32'(zone), 32'd2);
    sample_valid = 2'b01;
    sample_data  = {16'd0, 16'd950};
    @(negedge clk_1MHz);
    sample_valid = '0;
    sample_data  = '0;
    @(negedge clk_1MHz);
    check_eq("med_lat_hold", 32'(nearest_dist), 32'd100);
    @(negedge clk_1MHz);
    check_eq("med_dist", 32'(nearest_dist), 32'd900);
    check_eq("med_zone", 32'(zone), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
